spi_mpu_slave: RTL and testbench

SPI responder that models an MPU-style register-mapped sensor. It is the slave-side counterpart of the team's SPI register-read master, used in simulation and on-board loopback to exercise that master without the physical sensor. The block oversamples `sclk`/`ss_n`/`mosi` on the system clock and decodes 16-bit frames: an R/W + 7-bit address byte, then one data byte. It serves reads from a local register file and applies writes to it.

---
 rtl/spi_mpu_slave_pkg.sv | 20 ++
 rtl/spi_mpu_slave_sync.sv | 36 +++
 rtl/spi_mpu_slave.sv | 159 +++++++++++++++
 tb/tb_spi_mpu_slave.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_mpu_slave_pkg.sv
// Shared definitions for the SPI MPU-style register responder:
// FSM encoding, frame geometry and fixed addresses.
package spi_mpu_slave_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_DONE
   } state_t;

   localparam logic [6:0] ADDR_WHO_AM_I = 7'h75;
   localparam int         RW_BIT        = 15;
   localparam int         FRAME_LEN     = 16;

   // Bit-counter values at the last rising edge of the address byte and of the frame.
   localparam logic [3:0] LAST_ADDR_BIT = 4'(FRAME_LEN / 2 - 1);
   localparam logic [3:0] LAST_BIT      = 4'(FRAME_LEN - 1);

endpackage

// File: rtl/spi_mpu_slave_sync.sv
// Two-flop synchronizer with registered rise/fall detect; an edge on din is
// reported three clk cycles after it occurs.
module sync_edge #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic sync,
   output logic rise,
   output logic fall
);

   logic meta_reg, sync_reg, prev_reg, rise_reg, fall_reg;

   always_ff @(posedge clk) begin
      if (!rst) begin
         meta_reg <= RST_VAL;
         sync_reg <= RST_VAL;
         prev_reg <= RST_VAL;
         rise_reg <= 1'b0;
         fall_reg <= 1'b0;
      end else begin
         meta_reg <= din;
         sync_reg <= meta_reg;
         prev_reg <= sync_reg;
         rise_reg <= sync_reg & ~prev_reg;
         fall_reg <= ~sync_reg & prev_reg;
      end
   end

   assign sync = sync_reg;
   assign rise = rise_reg;
   assign fall = fall_reg;

endmodule

// File: rtl/spi_mpu_slave.sv
// Mode-3 SPI slave emulating a register-mapped sensor: 16-bit frames of
// R/W + 7-bit address followed by one data byte, served from a local register file.
module spi_mpu_slave
   import spi_mpu_slave_pkg::*;
#(
   parameter int         NREG     = 16,
   parameter logic [7:0] WHO_AM_I = 8'h68
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sclk,
   input  logic       ss_n,
   input  logic       mosi,
   output logic       miso,
   output logic       busy,
   output logic       wr_valid,
   output logic [6:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       rd_strobe,
   output logic [6:0] rd_addr
);

   logic sclk_lvl_unused, sclk_rise, sclk_fall;
   logic ss_sync, ss_rise_unused, ss_fall;
   logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

   sync_edge #(.RST_VAL(1'b1)) u_sclk (
      .clk(clk), .rst(rst), .din(sclk),
      .sync(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
   );

   // Reset low so a frame in progress at reset produces no falling edge
   // and is ignored until ss_n has been seen high.
   sync_edge #(.RST_VAL(1'b0)) u_ss (
      .clk(clk), .rst(rst), .din(ss_n),
      .sync(ss_sync), .rise(ss_rise_unused), .fall(ss_fall)
   );

   sync_edge #(.RST_VAL(1'b1)) u_mosi (
      .clk(clk), .rst(rst), .din(mosi),
      .sync(mosi_sync), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
   );

   state_t      state_reg, state_next;
   logic [3:0]  bit_cnt_reg;
   logic [14:0] shift_reg;
   logic [7:0]  rd_shift_reg;
   logic        miso_reg;
   logic        wr_valid_reg, rd_strobe_reg;
   logic [6:0]  wr_addr_reg, rd_addr_reg;
   logic [7:0]  wr_data_reg;
   logic [7:0]  regs [NREG];

   logic [15:0] cur_word;
   logic        shift_en, addr_done, frame_done;
   logic [7:0]  rd_value;

   // Frame as it stands once the bit arriving on this rising edge is included.
   assign cur_word = {shift_reg, mosi_sync};
   assign shift_en = sclk_rise && !ss_sync && (state_reg == ST_ADDR || state_reg == ST_DATA);

   always_comb begin
      state_next = state_reg;
      addr_done  = 1'b0;
      frame_done = 1'b0;
      if (ss_sync) begin
         state_next = ST_IDLE;
      end else begin
         case (state_reg)
            ST_IDLE: if (ss_fall) state_next = ST_ADDR;
            ST_ADDR: if (sclk_rise && bit_cnt_reg == LAST_ADDR_BIT) begin
               state_next = ST_DATA;
               addr_done  = 1'b1;
            end
            ST_DATA: if (sclk_rise && bit_cnt_reg == LAST_BIT) begin
               state_next = ST_DONE;
               frame_done = 1'b1;
            end
            default: state_next = state_reg;
         endcase
      end
   end

   always_comb begin
      rd_value = 8'h00;
      for (int i = 0; i < NREG; i++) begin
         if (cur_word[6:0] == 7'(i)) rd_value = regs[i];
      end
      if (cur_word[6:0] == ADDR_WHO_AM_I) rd_value = WHO_AM_I;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg     <= ST_IDLE;
         bit_cnt_reg   <= '0;
         shift_reg     <= '0;
         rd_shift_reg  <= 8'hFF;
         miso_reg      <= 1'b1;
         wr_valid_reg  <= 1'b0;
         wr_addr_reg   <= '0;
         wr_data_reg   <= '0;
         rd_strobe_reg <= 1'b0;
         rd_addr_reg   <= '0;
      end else begin
         state_reg     <= state_next;
         wr_valid_reg  <= 1'b0;
         rd_strobe_reg <= 1'b0;

         if (state_reg == ST_IDLE && state_next == ST_ADDR) begin
            bit_cnt_reg <= '0;
         end else if (shift_en) begin
            bit_cnt_reg <= bit_cnt_reg + 4'd1;
            shift_reg   <= cur_word[14:0];
         end

         // Write frames preload all ones so miso keeps idling high.
         if (addr_done) begin
            rd_shift_reg <= cur_word[RW_BIT - 8] ? rd_value : 8'hFF;
            if (cur_word[RW_BIT - 8]) begin
               rd_strobe_reg <= 1'b1;
               rd_addr_reg   <= cur_word[6:0];
            end
         end

         if (frame_done && !cur_word[RW_BIT]) begin
            wr_valid_reg <= 1'b1;
            wr_addr_reg  <= cur_word[14:8];
            wr_data_reg  <= cur_word[7:0];
         end

         if (state_next != ST_DATA) begin
            miso_reg <= 1'b1;
         end else if (state_reg == ST_DATA && sclk_fall) begin
            miso_reg     <= rd_shift_reg[7];
            rd_shift_reg <= {rd_shift_reg[6:0], 1'b1};
         end
      end
   end

   // Addresses at or above NREG (including WHO_AM_I) match no entry, so those writes drop.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) regs[i] <= 8'h00;
      end else if (frame_done && !cur_word[RW_BIT]) begin
         for (int i = 0; i < NREG; i++) begin
            if (cur_word[14:8] == 7'(i)) regs[i] <= cur_word[7:0];
         end
      end
   end

   assign miso      = miso_reg;
   assign busy      = (state_reg != ST_IDLE);
   assign wr_valid  = wr_valid_reg;
   assign wr_addr   = wr_addr_reg;
   assign wr_data   = wr_data_reg;
   assign rd_strobe = rd_strobe_reg;
   assign rd_addr   = rd_addr_reg;

endmodule

// File: tb/tb_spi_mpu_slave.sv
// Scoreboard bench for spi_mpu_slave: a mode-3 SPI master drives frames,
// a register-map model predicts pulses and read bytes, a monitor compares.
module tb_spi_mpu_slave;

   localparam int NREG = 16;
   localparam int HALF = 8;

   logic       clk, rst, sclk, ss_n, mosi;
   logic       miso, busy, wr_valid, rd_strobe;
   logic [6:0] wr_addr, rd_addr;
   logic [7:0] wr_data;

   spi_mpu_slave #(.NREG(NREG), .WHO_AM_I(8'h68)) dut (
      .clk(clk), .rst(rst), .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
      .miso(miso), .busy(busy), .wr_valid(wr_valid), .wr_addr(wr_addr),
      .wr_data(wr_data), .rd_strobe(rd_strobe), .rd_addr(rd_addr)
   );

   typedef struct {
      bit         is_rd;
      logic [6:0] addr;
      logic [7:0] data;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] rd_exp_q[$];
   logic [7:0] rd_obs_q[$];
   logic [7:0] model [128];
   int         n_vec = 0;
   int         n_err = 0;
   int         cycles = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cycles++;
      if (cycles > 200000) begin
         $display("FAIL watchdog: actual=%0d cycles required<=200000", cycles);
         $fatal(1);
      end
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] model_read(input logic [6:0] a);
      if (int'(a) < NREG) return model[a];
      if (a == 7'h75) return 8'h68;
      return 8'h00;
   endfunction

   // Monitor: pops the scoreboard whenever the DUT presents a pulse or a read byte completes.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         if (wr_valid) begin
            if (exp_q.size() == 0) check("wr_unexpected", 16'(wr_valid), 16'd0);
            else begin
               e = exp_q.pop_front();
               check("wr_kind", 16'(e.is_rd), 16'd0);
               check("wr_addr", 16'(wr_addr), 16'(e.addr));
               check("wr_data", 16'(wr_data), 16'(e.data));
               $display("write addr=%h data=%h", wr_addr, wr_data);
            end
         end
         if (rd_strobe) begin
            if (exp_q.size() == 0) check("rd_unexpected", 16'(rd_strobe), 16'd0);
            else begin
               e = exp_q.pop_front();
               check("rd_kind", 16'(e.is_rd), 16'd1);
               check("rd_addr", 16'(rd_addr), 16'(e.addr));
            end
         end
      end
      if (rd_obs_q.size() > 0 && rd_exp_q.size() > 0) begin
         logic [7:0] o, x;
         o = rd_obs_q.pop_front();
         x = rd_exp_q.pop_front();
         check("rd_miso_byte", 16'(o), 16'(x));
         $display("read  addr=%h miso=%h", rd_addr, o);
      end
   end

   // mode 0: complete frame of ncyc sclk cycles; 1: ss_n abort after cut
   // rising edges; 2: reset after cut rising edges, rest of frame still clocked.
   task automatic frame(input bit rw, input logic [6:0] a, input logic [7:0] d,
                        input int ncyc, input int mode, input int cut);
      logic [15:0] word;
      logic [7:0]  got;
      bit          extra_ok;
      int          nrun;
      exp_t        e;
      word = {rw, a, d};
      got = 8'h00;
      extra_ok = 1'b1;
      nrun = (mode == 0) ? ncyc : cut;
      if (rw) begin
         if (mode == 0 || cut >= 8) begin
            e.is_rd = 1'b1; e.addr = a; e.data = 8'h00;
            exp_q.push_back(e);
         end
         if (mode == 0) rd_exp_q.push_back(model_read(a));
      end else if (mode == 0) begin
         e.is_rd = 1'b0; e.addr = a; e.data = d;
         exp_q.push_back(e);
         if (int'(a) < NREG) model[a] = d;
      end

      ss_n = 1'b0;
      repeat (8) @(negedge clk);
      for (int i = 0; i < nrun; i++) begin
         sclk = 1'b0;
         mosi = (i < 16) ? word[15 - i] : 1'b1;
         repeat (HALF) @(negedge clk);
         sclk = 1'b1;
         if (i >= 8 && i < 16) got = {got[6:0], miso};
         else if (i >= 16 && miso !== 1'b1) extra_ok = 1'b0;
         repeat (HALF) @(negedge clk);
      end

      if (mode == 1) begin
         check("abort_busy_high", 16'(busy), 16'd1);
         ss_n = 1'b1;
         repeat (5) @(negedge clk);
         check("abort_busy_low", 16'(busy), 16'd0);
         check("abort_miso", 16'(miso), 16'd1);
      end else if (mode == 2) begin
         rst = 1'b0;
         repeat (3) @(negedge clk);
         rst = 1'b1;
         @(negedge clk);
         check("rst_miso", 16'(miso), 16'd1);
         check("rst_busy", 16'(busy), 16'd0);
         check("rst_wr_addr", 16'(wr_addr), 16'd0);
         for (int k = 0; k < NREG; k++) model[k] = 8'h00;
         for (int i = cut; i < 16; i++) begin
            sclk = 1'b0;
            mosi = 1'($urandom_range(0, 1));
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            if (miso !== 1'b1 || busy !== 1'b0) extra_ok = 1'b0;
            repeat (HALF) @(negedge clk);
         end
         check("rst_rest_ignored", 16'(extra_ok), 16'd1);
         ss_n = 1'b1;
         repeat (6) @(negedge clk);
      end else begin
         repeat (HALF) @(negedge clk);
         ss_n = 1'b1;
         repeat (6) @(negedge clk);
         if (rw) rd_obs_q.push_back(got);
         if (ncyc > 16) check("extra_clk_miso", 16'(extra_ok), 16'd1);
         check("idle_miso", 16'(miso), 16'd1);
      end
      repeat (4) @(negedge clk);
   endtask

   initial begin
      for (int k = 0; k < 128; k++) model[k] = 8'h00;
      rst = 1'b0; ss_n = 1'b1; sclk = 1'b1; mosi = 1'b1;
      repeat (5) @(negedge clk);
      check("reset_miso", 16'(miso), 16'd1);
      check("reset_busy", 16'(busy), 16'd0);
      check("reset_wr_valid", 16'(wr_valid), 16'd0);
      check("reset_rd_strobe", 16'(rd_strobe), 16'd0);
      check("reset_wr_addr", 16'(wr_addr), 16'd0);
      check("reset_wr_data", 16'(wr_data), 16'd0);
      check("reset_rd_addr", 16'(rd_addr), 16'd0);
      rst = 1'b1;
      repeat (5) @(negedge clk);

      frame(1'b0, 7'h05, 8'hA7, 16, 0, 0);
      frame(1'b1, 7'h05, 8'h00, 16, 0, 0);
      frame(1'b1, 7'h75, 8'h00, 16, 0, 0);
      frame(1'b0, 7'h75, 8'h00, 16, 0, 0);
      frame(1'b1, 7'h75, 8'h00, 16, 0, 0);
      frame(1'b1, 7'h40, 8'h00, 16, 0, 0);
      frame(1'b0, 7'h40, 8'hFF, 16, 0, 0);
      frame(1'b1, 7'h40, 8'h00, 16, 0, 0);
      frame(1'b0, 7'h03, 8'h5A, 16, 0, 0);
      frame(1'b0, 7'h03, 8'hC3, 16, 1, 10);
      frame(1'b1, 7'h03, 8'h00, 16, 0, 0);
      frame(1'b0, 7'h02, 8'h3C, 16, 0, 0);
      frame(1'b1, 7'h02, 8'h00, 24, 0, 0);
      frame(1'b1, 7'h02, 8'h00, 16, 2, 10);
      frame(1'b1, 7'h05, 8'h00, 16, 0, 0);

      for (int n = 0; n < 30; n++) begin
         bit         rw;
         int         sel;
         logic [6:0] a;
         rw  = 1'($urandom_range(0, 1));
         sel = $urandom_range(0, 9);
         if (sel < 6)       a = 7'($urandom_range(0, NREG - 1));
         else if (sel == 6) a = 7'h75;
         else if (sel == 7) a = 7'(NREG);
         else               a = 7'($urandom_range(0, 127));
         frame(rw, a, 8'($urandom), 16, 0, 0);
      end

      repeat (20) @(negedge clk);
      check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
      check("read_queue_drained", 16'(rd_exp_q.size()), 16'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
